// File: rtl/txn_mon_pkg.sv
// Shared types and widths for the ap_ctrl_hs transaction tracker.
// Record layout is fixed here so both stall-count builds produce identical records.
package txn_mon_pkg;

  localparam int TXN_CYC_W      = 32;
  localparam int TXN_ID_W       = 16;
  localparam int TXN_MAX_OUT    = 4;
  localparam int TXN_FIFO_DEPTH = 8;

  localparam logic [15:0] DROP_SAT = 16'hFFFF;

  typedef struct packed {
    logic [TXN_ID_W-1:0]  id;
    logic [TXN_CYC_W-1:0] start_cyc;
    logic [TXN_CYC_W-1:0] latency;
    logic [TXN_CYC_W-1:0] interval;
    logic [TXN_CYC_W-1:0] stall;
  } txn_rec_t;

  // One start-queue entry: everything known at start time.
  typedef struct packed {
    logic [TXN_CYC_W-1:0] start_cyc;
    logic [TXN_CYC_W-1:0] interval;
    logic [TXN_CYC_W-1:0] stall;
  } start_ent_t;

endpackage

// File: rtl/txn_rec_fifo.sv
// Generic synchronous FIFO with full/empty flags; DEPTH must be a power of 2 (>= 2).
// A push while full succeeds when a pop happens in the same cycle.
module txn_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ap_txn_tracker.sv
// Tracks an ap_ctrl_hs DUT and emits one timestamped record per completed transaction.
// Optional TXN_STALL_CNT_EN adds a start-stall counter reported in the record's stall field.
module ap_txn_tracker
  import txn_mon_pkg::*;
#(
  parameter int CYC_W      = TXN_CYC_W,
  parameter int ID_W       = TXN_ID_W,
  parameter int MAX_OUT    = TXN_MAX_OUT,
  parameter int FIFO_DEPTH = TXN_FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ap_start,
  input  logic        ap_ready,
  input  logic        ap_done,
  input  logic        ap_continue,
  input  logic        finish,
  output logic        rec_valid,
  input  logic        rec_ready,
  output txn_rec_t    rec_data,
  output logic [15:0] drop_cnt,
  output logic        proto_err,
  output logic        drained
);

  logic [CYC_W-1:0]     cyc_q;
  logic [CYC_W-1:0]     prev_start_q;
  logic                 has_prev_q;
  logic                 fin_q;
  logic [ID_W-1:0]      id_q;
  logic                 start_ev, done_ev, bypass, start_acc;
  logic                 q_push, q_pop, q_full, q_empty;
  start_ent_t           q_wdata, q_rdata;
  logic [CYC_W-1:0]     interval_now, start_sel, lat_now;
  logic [TXN_CYC_W-1:0] stall_now;
  txn_rec_t             rec_new, pend_rec_q, out_rdata;
  logic                 pend_q, rec_fire;
  logic                 out_pop, out_full, out_empty;

  assign start_ev  = ap_start & ap_ready & ~fin_q;
  assign done_ev   = ap_done & ap_continue;
  // An empty-queue done is satisfied by a same-cycle start without touching the queue.
  assign bypass    = done_ev & q_empty & start_ev;
  assign q_pop     = done_ev & ~q_empty;
  assign start_acc = start_ev & (~q_full | q_pop);
  assign q_push    = start_acc & ~bypass;
  assign rec_fire  = q_pop | bypass;

  assign interval_now = has_prev_q ? (cyc_q - prev_start_q) : '0;

`ifdef TXN_STALL_CNT_EN
  logic [TXN_CYC_W-1:0] stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_q <= '0;
    else if (start_ev)
      stall_q <= '0;
    else if (ap_start && !ap_ready && !fin_q && (stall_q != '1))
      stall_q <= stall_q + TXN_CYC_W'(1);
  end

  assign stall_now = stall_q;
`else
  assign stall_now = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc_q        <= '0;
      prev_start_q <= '0;
      has_prev_q   <= 1'b0;
      fin_q        <= 1'b0;
      id_q         <= '0;
      proto_err    <= 1'b0;
    end else begin
      cyc_q <= cyc_q + CYC_W'(1);
      if (finish) fin_q <= 1'b1;
      if (start_acc) begin
        prev_start_q <= cyc_q;
        has_prev_q   <= 1'b1;
      end
      if (rec_fire) id_q <= id_q + ID_W'(1);
      if ((done_ev && q_empty && !start_ev) || (start_ev && q_full && !q_pop))
        proto_err <= 1'b1;
    end
  end

  always_comb begin
    q_wdata           = '0;
    q_wdata.start_cyc = TXN_CYC_W'(cyc_q);
    q_wdata.interval  = TXN_CYC_W'(interval_now);
    q_wdata.stall     = stall_now;
  end

  txn_rec_fifo #(.WIDTH($bits(start_ent_t)), .DEPTH(MAX_OUT)) u_start_q (
    .clock (clock),
    .reset (reset),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  assign start_sel = bypass ? cyc_q : q_rdata.start_cyc[CYC_W-1:0];
  assign lat_now   = cyc_q - start_sel;

  always_comb begin
    rec_new           = '0;
    rec_new.id        = TXN_ID_W'(id_q);
    rec_new.start_cyc = TXN_CYC_W'(start_sel);
    rec_new.latency   = TXN_CYC_W'(lat_now);
    rec_new.interval  = bypass ? TXN_CYC_W'(interval_now) : q_rdata.interval;
    rec_new.stall     = bypass ? stall_now : q_rdata.stall;
  end

  // One register stage between the done event and the output FIFO write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q     <= 1'b0;
      pend_rec_q <= '0;
      drop_cnt   <= '0;
      drained    <= 1'b0;
    end else begin
      pend_q <= rec_fire;
      if (rec_fire) pend_rec_q <= rec_new;
      if (pend_q && out_full && !out_pop && (drop_cnt != DROP_SAT))
        drop_cnt <= drop_cnt + 16'd1;
      drained <= fin_q & q_empty & out_empty & ~pend_q;
    end
  end

  assign out_pop = ~out_empty & rec_ready;

  txn_rec_fifo #(.WIDTH($bits(txn_rec_t)), .DEPTH(FIFO_DEPTH)) u_rec_fifo (
    .clock (clock),
    .reset (reset),
    .push  (pend_q),
    .wdata (pend_rec_q),
    .pop   (out_pop),
    .rdata (out_rdata),
    .full  (out_full),
    .empty (out_empty)
  );

  assign rec_valid = ~out_empty;
  assign rec_data  = out_empty ? '0 : out_rdata;

endmodule
